// File: rtl/ascon_input_packer_pkg.sv
// Shared definitions for the ASCON-128 input packer.
//   ASCON_IV      : initial block presented with start_o
//   ASCON_PAD_BLK : stand-alone 10* pad block, used after a full final block
//   blk_type_t    : block type tag carried on blk_type_o
//   pk_state_t    : packer FSM state encoding
package ascon_pack;

    localparam int          RATE_W        = 64;
    localparam logic [63:0] ASCON_IV      = 64'h80400C0600000000;
    localparam logic [63:0] ASCON_PAD_BLK = 64'h8000000000000000;

    typedef enum logic [1:0] {
        BLK_IV = 2'd0,
        BLK_AD = 2'd1,
        BLK_PT = 2'd2
    } blk_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_IV,
        ST_FILL_AD,
        ST_SEND_AD,
        ST_FILL_PT,
        ST_SEND_PT
    } pk_state_t;

endpackage

// File: rtl/ascon_input_packer_shifter.sv
// Byte-slot insert with 10* padding for one 64-bit rate block.
//   blk_i  : current partially filled block
//   idx_i  : slot (0..7) the new byte goes into; slot 0 is [63:56]
//   byte_i : new byte
//   last_i : new byte is the last of its phase -> 0x80 in the next slot and
//            all later slots forced to zero
//   blk_o  : updated block
module ascon_byte_shifter (
    input  logic [63:0] blk_i,
    input  logic [2:0]  idx_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [63:0] blk_o
);

    always_comb begin
        blk_o = blk_i;
        for (int k = 0; k < 8; k++) begin
            if (k == int'(idx_i)) begin
                blk_o[63-8*k -: 8] = byte_i;
            end else if (last_i && k == int'(idx_i) + 1) begin
                blk_o[63-8*k -: 8] = 8'h80;
            end else if (last_i && k > int'(idx_i) + 1) begin
                blk_o[63-8*k -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/ascon_input_packer.sv
// Packs an AD/PT byte stream into padded 64-bit ASCON rate blocks and
// presents IV, AD and PT blocks in protocol order on a valid/ready port.
//   clock_i, resetb_i         : clock, async active-low reset
//   msg_start_i, ad_present_i : begin a message (IDLE only), AD phase present
//   byte_*_i / byte_ready_o   : byte stream input with handshake
//   data_o, data_valid_o      : block output, blk_ready_i consumes it
//   start_o, blk_type_o       : IV marker, block type
//   blk_last_o                : final block of the current phase
//   busy_o, err_o             : not idle, sticky protocol error
// Optional build macro ASCON_PACKER_CHK_EN enables protocol checking on err_o;
// without it err_o is tied low.
module ascon_input_packer
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        msg_start_i,
    input  logic        ad_present_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    input  logic        byte_is_ad_i,
    output logic        byte_ready_o,
    output logic [63:0] data_o,
    output logic        data_valid_o,
    input  logic        blk_ready_i,
    output logic        start_o,
    output logic [1:0]  blk_type_o,
    output logic        blk_last_o,
    output logic        busy_o,
    output logic        err_o
);

    pk_state_t   state_q, state_d;
    logic [63:0] blk_q, blk_d, ins_blk;
    logic [2:0]  idx_q, idx_d;
    logic        ad_q, ad_d;
    logic        pend_q, pend_d;   // full final block sent, pad block still owed
    logic        last_q, last_d;
    logic        in_fill, in_send;
    blk_type_t   ty;

    assign in_fill = (state_q == ST_FILL_AD) || (state_q == ST_FILL_PT);
    assign in_send = (state_q == ST_SEND_IV) || (state_q == ST_SEND_AD) ||
                     (state_q == ST_SEND_PT);

    ascon_byte_shifter u_shift (
        .blk_i  (blk_q),
        .idx_i  (idx_q),
        .byte_i (byte_i),
        .last_i (byte_last_i),
        .blk_o  (ins_blk)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        idx_d   = idx_q;
        ad_d    = ad_q;
        pend_d  = pend_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (msg_start_i) begin
                    state_d = ST_SEND_IV;
                    blk_d   = ASCON_IV;
                    ad_d    = ad_present_i;
                    last_d  = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            ST_SEND_IV: begin
                if (blk_ready_i) begin
                    state_d = ad_q ? ST_FILL_AD : ST_FILL_PT;
                    blk_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_FILL_AD, ST_FILL_PT: begin
                if (byte_valid_i) begin
                    blk_d = ins_blk;
                    idx_d = idx_q + 3'd1;
                    if (byte_last_i || idx_q == 3'd7) begin
                        state_d = (state_q == ST_FILL_AD) ? ST_SEND_AD : ST_SEND_PT;
                        // A last byte filling slot 7 leaves no room for the pad
                        last_d  = byte_last_i && (idx_q != 3'd7);
                        pend_d  = byte_last_i && (idx_q == 3'd7);
                    end
                end
            end
            ST_SEND_AD, ST_SEND_PT: begin
                if (blk_ready_i) begin
                    if (pend_q) begin
                        blk_d  = ASCON_PAD_BLK;
                        last_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        blk_d  = '0;
                        idx_d  = '0;
                        last_d = 1'b0;
                        if (state_q == ST_SEND_AD)
                            state_d = last_q ? ST_FILL_PT : ST_FILL_AD;
                        else
                            state_d = last_q ? ST_IDLE : ST_FILL_PT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            idx_q   <= '0;
            ad_q    <= 1'b0;
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            idx_q   <= idx_d;
            ad_q    <= ad_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_FILL_AD, ST_SEND_AD: ty = BLK_AD;
            ST_FILL_PT, ST_SEND_PT: ty = BLK_PT;
            default:                ty = BLK_IV;
        endcase
    end

    assign byte_ready_o = in_fill;
    assign data_valid_o = in_send;
    assign data_o       = blk_q;
    assign start_o      = (state_q == ST_SEND_IV);
    assign blk_type_o   = ty;
    assign blk_last_o   = last_q;
    assign busy_o       = (state_q != ST_IDLE);

`ifdef ASCON_PACKER_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (msg_start_i && state_q != ST_IDLE)                    err_d = 1'b1;
        if (byte_valid_i && !in_fill)                             err_d = 1'b1;
        if (byte_valid_i && state_q == ST_FILL_AD && !byte_is_ad_i) err_d = 1'b1;
        if (byte_valid_i && state_q == ST_FILL_PT && byte_is_ad_i)  err_d = 1'b1;
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_is_ad;
    assign unused_is_ad = byte_is_ad_i;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_input_packer.sv
module tb_ascon_input_packer;
    import ascon_pack::*;

    logic        clock_i = 1'b0;
    logic        resetb_i = 1'b0;
    logic        msg_start_i = 1'b0, ad_present_i = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0, byte_last_i = 1'b0, byte_is_ad_i = 1'b0;
    logic        byte_ready_o;
    logic [63:0] data_o;
    logic        data_valid_o;
    logic        blk_ready_i = 1'b0;
    logic        start_o;
    logic [1:0]  blk_type_o;
    logic        blk_last_o, busy_o, err_o;

    ascon_input_packer dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .msg_start_i(msg_start_i),
        .ad_present_i(ad_present_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
        .byte_last_i(byte_last_i), .byte_is_ad_i(byte_is_ad_i),
        .byte_ready_o(byte_ready_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .blk_ready_i(blk_ready_i), .start_o(start_o), .blk_type_o(blk_type_o),
        .blk_last_o(blk_last_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  ty;
        logic        last;
        logic        st;
    } exp_t;
    typedef exp_t       exp_qt[$];
    typedef logic [7:0] bq_t[$];

    int    checks = 0, failures = 0;
    exp_t  exp_q[$];
    int    rdy_mode = 0;   // 0 always ready, 1 random, 2 stall 5 cycles per block
    int    stall_cnt = 0;

    task automatic check(input bit ok, input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: a phase of n bytes becomes n/8+1 blocks; byte k lands in block
    // k/8 slot k%8, the slot at position n holds 0x80, everything else is zero.
    function automatic exp_qt phase_blocks(input bq_t q, input logic [1:0] ty);
        exp_qt r;
        exp_t  e;
        int    n = q.size();
        int    nb = n / 8 + 1;
        for (int i = 0; i < nb; i++) begin
            e.d = '0;
            for (int j = 0; j < 8; j++) begin
                int k = 8 * i + j;
                if (k < n)       e.d[63-8*j -: 8] = q[k];
                else if (k == n) e.d[63-8*j -: 8] = 8'h80;
            end
            e.ty = ty; e.last = (i == nb - 1); e.st = 1'b0;
            r.push_back(e);
        end
        return r;
    endfunction

    function automatic exp_qt msg_model(input logic adp, input bq_t ad, input bq_t pt);
        exp_qt r, p;
        exp_t  e;
        e.d = ASCON_IV; e.ty = 2'd0; e.last = 1'b0; e.st = 1'b1;
        r.push_back(e);
        if (adp) begin
            p = phase_blocks(ad, 2'd1);
            foreach (p[i]) r.push_back(p[i]);
        end
        p = phase_blocks(pt, 2'd2);
        foreach (p[i]) r.push_back(p[i]);
        return r;
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Ready generator
    initial forever begin
        @(posedge clock_i); #1;
        case (rdy_mode)
            0: blk_ready_i = 1'b1;
            1: blk_ready_i = ($urandom_range(0, 3) != 0);
            default: begin
                if (data_valid_o) begin
                    if (stall_cnt < 5) begin blk_ready_i = 1'b0; stall_cnt++; end
                    else begin blk_ready_i = 1'b1; stall_cnt = 0; end
                end else begin
                    blk_ready_i = 1'b0; stall_cnt = 0;
                end
            end
        endcase
    end

    // Compare process: every valid cycle must show the head of the expected queue
    initial forever begin
        @(negedge clock_i);
        if (resetb_i) begin
            if (byte_ready_o && data_valid_o)
                check(1'b0, "ready_and_valid", {62'd0, byte_ready_o, data_valid_o}, 64'd1);
            if (data_valid_o) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_block", data_o, 64'd0);
                end else begin
                    check(data_o == exp_q[0].d && blk_type_o == exp_q[0].ty &&
                          blk_last_o == exp_q[0].last && start_o == exp_q[0].st,
                          $sformatf("block ty%0d/last%0d/st%0d", blk_type_o, blk_last_o, start_o),
                          data_o, exp_q[0].d);
                    if (blk_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last, input logic isad,
                             input int k);
        int t = 0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clock_i); #1; end
        while (!byte_ready_o && t < 200) begin @(posedge clock_i); #1; t++; end
        if (!byte_ready_o) begin
            check(1'b0, "byte_ready_timeout", 64'd0, 64'd1);
            return;
        end
        byte_i = b; byte_last_i = last; byte_is_ad_i = isad; byte_valid_i = 1'b1;
        @(posedge clock_i); #1;
        byte_valid_i = 1'b0; byte_last_i = 1'b0;
        if (last || (k % 8 == 7))
            check(data_valid_o && !byte_ready_o, "blk_latency",
                  {62'd0, data_valid_o, byte_ready_o}, 64'd2);
    endtask

    task automatic start_msg(input logic adp, input bq_t ad, input bq_t pt);
        exp_qt m = msg_model(adp, ad, pt);
        int t = 0;
        while (busy_o && t < 2000) begin @(posedge clock_i); #1; t++; end
        foreach (m[i]) exp_q.push_back(m[i]);
        msg_start_i = 1'b1; ad_present_i = adp;
        @(posedge clock_i); #1;
        msg_start_i = 1'b0; ad_present_i = 1'b0;
        check(data_valid_o && start_o, "iv_latency", {62'd0, data_valid_o, start_o}, 64'd3);
    endtask

    task automatic run_msg(input logic adp, input bq_t ad, input bq_t pt, input int flip);
        int t = 0;
        start_msg(adp, ad, pt);
        if (adp) foreach (ad[i]) send_byte(ad[i], i == ad.size() - 1, 1'b1, i);
        foreach (pt[i]) send_byte(pt[i], i == pt.size() - 1, (i == flip), i);
        while ((exp_q.size() != 0 || busy_o) && t < 2000) begin @(posedge clock_i); #1; t++; end
        check(exp_q.size() == 0 && !busy_o, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check(!byte_ready_o && !data_valid_o && !start_o && !blk_last_o && !busy_o &&
              !err_o && blk_type_o == 2'd0, {tag, "_ctl"},
              {55'd0, byte_ready_o, data_valid_o, start_o, blk_last_o, busy_o, err_o, blk_type_o},
              64'd0);
        check(data_o == 64'd0, {tag, "_data"}, data_o, 64'd0);
    endtask

    initial begin
        bq_t   atob, rdv, ad8, aa, empty, ad, pt;
        exp_qt m;
        atob  = '{8'h41, 8'h20, 8'h74, 8'h6f, 8'h20, 8'h42};
        rdv   = str2q("RDV au Ti'bar ce soir ?");
        ad8   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        aa    = '{8'hAA};

        // Pin the model to hand-computed blocks
        m = msg_model(1'b1, atob, rdv);
        check(m.size() == 5, "pin_cnt", 64'(m.size()), 64'd5);
        if (m.size() == 5) begin
            check(m[1].d == 64'h4120746f20428000 && m[1].last, "pin_atob", m[1].d, 64'h4120746f20428000);
            check(m[2].d == 64'h5244562061752054, "pin_pt0", m[2].d, 64'h5244562061752054);
            check(m[3].d == 64'h6927626172206365, "pin_pt1", m[3].d, 64'h6927626172206365);
            check(m[4].d == 64'h20736f6972203f80 && m[4].last, "pin_pt2", m[4].d, 64'h20736f6972203f80);
        end
        m = msg_model(1'b1, ad8, aa);
        check(m[1].d == 64'h0001020304050607 && !m[1].last, "pin_ad8", m[1].d, 64'h0001020304050607);
        check(m[2].d == 64'h8000000000000000 && m[2].last, "pin_pad", m[2].d, 64'h8000000000000000);
        m = msg_model(1'b0, empty, aa);
        check(m.size() == 2 && m[1].d == 64'hAA80000000000000 && m[1].ty == 2'd2,
              "pin_aa", m[1].d, 64'hAA80000000000000);

        #12;
        check_reset_outs("reset");
        @(posedge clock_i); #1;
        resetb_i = 1'b1;
        @(posedge clock_i); #1;
        check_reset_outs("idle");

        rdy_mode = 0;
        run_msg(1'b1, atob, rdv, -1);
        run_msg(1'b1, ad8, aa, -1);
        run_msg(1'b0, empty, aa, -1);
        rdy_mode = 2;
        run_msg(1'b1, atob, rdv, -1);
        run_msg(1'b1, ad8, aa, -1);
        rdy_mode = 0;

        // Abort mid-PT
        start_msg(1'b0, empty, rdv);
        for (int i = 0; i < 3; i++) send_byte(rdv[i], 1'b0, 1'b0, i);
        resetb_i = 1'b0;
        #1;
        check_reset_outs("mid_reset");
        exp_q.delete();
        @(posedge clock_i); #1;
        resetb_i = 1'b1;
        run_msg(1'b1, atob, aa, -1);

        for (int n = 0; n < 25; n++) begin
            int adl = $urandom_range(1, 20);
            int ptl = $urandom_range(1, 20);
            ad.delete(); pt.delete();
            for (int i = 0; i < adl; i++) ad.push_back(8'($urandom));
            for (int i = 0; i < ptl; i++) pt.push_back(8'($urandom));
            rdy_mode = $urandom_range(0, 2);
            run_msg(1'($urandom_range(0, 1)), ad, pt, -1);
        end
        rdy_mode = 0;

        check(err_o == 1'b0, "err_clean", {63'd0, err_o}, 64'd0);
        pt = '{8'h11, 8'h22, 8'h33};
        run_msg(1'b0, empty, pt, 1);
`ifdef ASCON_PACKER_CHK_EN
        check(err_o == 1'b1, "err_phase", {63'd0, err_o}, 64'd1);
`else
        check(err_o == 1'b0, "err_tied", {63'd0, err_o}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_input_packer.md
# ascon_input_packer

Upstream formatter for the ASCON-128 core: accepts a byte stream of associated data (AD) and plaintext (PT), packs it into 64-bit rate blocks, applies ASCON 10* padding, and presents the IV, AD and PT blocks in protocol order on a valid/ready block interface. A thin glue wrapper converts this interface into the core's `data_i`, `data_valid_i` and `start_i` signals. Block sequencing lives here, so the core never sees partial or unpadded data.

## Interface
- No parameters. Rate (64), IV value and block-type encoding come from the shared package.
- `clock_i` in 1: single clock, rising edge.
- `resetb_i` in 1: asynchronous, active-low reset.
- `msg_start_i` in 1: pulse; begins a new message. Honoured only in IDLE.
- `ad_present_i` in 1: sampled with `msg_start_i`. 0 means the AD phase is skipped.
- `byte_i` in 8: input byte.
- `byte_valid_i` in 1: byte qualifier.
- `byte_last_i` in 1: last byte of the current phase (AD or PT).
- `byte_is_ad_i` in 1: byte belongs to AD (1) or PT (0).
- `byte_ready_o` out 1: byte accepted when `byte_valid_i & byte_ready_o`.
- `data_o` out 64: packed block. The first byte of a block sits in [63:56].
- `data_valid_o` out 1: block valid.
- `blk_ready_i` in 1: block consumed when `data_valid_o & blk_ready_i`.
- `start_o` out 1: high together with `data_valid_o` for the IV block only.
- `blk_type_o` out 2: type of the block on `data_o` (IV, AD or PT).
- `blk_last_o` out 1: final block of the current phase.
- `busy_o` out 1: high whenever the FSM is not in IDLE.
- `err_o` out 1: sticky protocol error. See Configuration.

## Operation
- FSM states: IDLE, SEND_IV, FILL_AD, SEND_AD, FILL_PT, SEND_PT.
- IDLE → SEND_IV on `msg_start_i`. `data_o` = IV, `start_o` = 1, type IV.
- SEND_IV on accept → FILL_AD if `ad_present_i` was 1, else FILL_PT.
- FILL_x:
  - `byte_ready_o` = 1.
  - Byte k (0..7) is written to bits [63-8k : 56-8k]; a 3-bit index counts bytes.
  - Go to SEND_x when the 8th byte is accepted or `byte_last_i` is accepted.
- Padding on the last byte, when fewer than 8 bytes are in the block:
  - 0x80 goes in the next byte slot; all remaining slots are 0x00.
  - `blk_last_o` = 1.
- Last byte that completes a full block: that block goes out with `blk_last_o` = 0. An extra block 0x8000000000000000 with `blk_last_o` = 1 follows (`pad_pending` flag).
- SEND_x on accept:
  - If `pad_pending`: emit the pad block and stay in SEND_x.
  - Else, after the last AD block: → FILL_PT.
  - Else, after the last PT block: → IDLE.
  - Else: → FILL_x.
- PT phase always emits at least one block. `byte_last_i` on the first PT byte gives a single padded block.
- An empty PT is not supported; a message needs at least 1 PT byte.
- The block register is cleared to zero on entry to each FILL state.

## Timing
- Reset values: `byte_ready_o` = 0, `data_o` = 0, `data_valid_o` = 0, `start_o` = 0, `blk_type_o` = IV, `blk_last_o` = 0, `busy_o` = 0, `err_o` = 0. FSM = IDLE.
- `data_valid_o` and `start_o` rise 1 cycle after `msg_start_i`.
- Latency from accepting the 8th/last byte to `data_valid_o`: 1 cycle. `byte_ready_o` is low in the same cycle `data_valid_o` rises.
- `data_o`, `blk_*` and `start_o` are stable while `data_valid_o` & !`blk_ready_i`. There is no combinational path from `blk_ready_i` to `data_valid_o`.
- After a block is accepted: `byte_ready_o` = 1 on the next cycle. Throughput is 1 byte per cycle plus 1 cycle per block.
- `blk_ready_i` may be held high. The pad block then appears on the cycle right after the full block.
- `msg_start_i` outside IDLE is ignored.
- Reset mid-message: abort immediately to IDLE with all outputs at reset values. Any held block is dropped.

## Configuration
- `ASCON_PACKER_CHK_EN` defined:
  - `err_o` is set (sticky until reset) on `byte_is_ad_i` ≠ current phase, on `msg_start_i` while busy, or on any byte in IDLE/SEND states.
  - A mismatched byte is still accepted into the current phase.
- Undefined: `err_o` is tied 0 and no check logic is built. Behaviour is otherwise identical.

## Structure
- Shared package `ascon_pack` holds:
  - `ASCON_IV` = 64'h80400C0600000000 and `ASCON_PAD_BLK` = 64'h8000000000000000.
  - `blk_type_t` (IV = 0, AD = 1, PT = 2).
  - The packer state enum.
- Sub-module `ascon_byte_shifter`: byte-slot insert plus pad-mask generation, driven by the index. The FSM and handshake stay in the top.

## Test plan
- AD "A to B" (41 20 74 6f 20 42, last on 42), `blk_ready_i` = 1 → blocks 80400C0600000000 (`start_o` = 1), then 4120746f20428000 (AD, last).
- PT of 23 bytes ("RDV au Ti'bar ce soir ?") → 5244562061752054, 6927626172206365, 20736f6972203f80 (last).
- 8-byte AD 00..07 → 0001020304050607 (`blk_last_o` = 0) then 8000000000000000 (`blk_last_o` = 1), then the PT phase.
- `ad_present_i` = 0 with 1 PT byte AA → IV then AA80000000000000 (PT, last); no AD block ever appears.
- `blk_ready_i` held low 5 cycles on each block → `data_o` stable, `byte_ready_o` = 0 throughout; the same block sequence is produced.
- Reset asserted mid-PT, then a new message → outputs at reset values immediately; the new message's blocks are correct. With `ASCON_PACKER_CHK_EN`, an AD-flagged byte during PT sets `err_o`.
